mul_seq_unit: RTL

Iterative 32×32 multiplier implementing the RV32M multiply group: MUL, MULH, MULHSU and MULHU. Each cycle it retires 4 multiplier bits by summing four shifted partial products. This is the same four-operand accumulation that the carry-out detector checks, here consumed and folded into a 64-bit accumulator. It sits in the RV32M accelerator beside the divider and is driven by the execute stage through a start/done handshake.

---
 rtl/mul_pkg.sv | 25 ++
 rtl/mul_pp4.sv | 19 +
 rtl/mul_seq_unit.sv | 109 ++++++++++
 3 files changed

// File: rtl/mul_pkg.sv
// rtl/mul_pkg.sv - shared types and constants for the sequential RV32M multiplier
package mul_pkg;

    localparam int XLEN     = 32;
    localparam int ITER_CNT = 8;

    typedef enum logic [1:0] {
        MUL_OP_MUL    = 2'b00,
        MUL_OP_MULH   = 2'b01,
        MUL_OP_MULHSU = 2'b10,
        MUL_OP_MULHU  = 2'b11
    } mul_op_e;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_CALC,
        ST_FIX
    } mul_state_e;

    // 0x80000000 negates to itself, which is the correct unsigned magnitude
    function automatic logic [XLEN-1:0] mag_of(input logic [XLEN-1:0] x, input logic sgn);
        return (sgn & x[XLEN-1]) ? (~x + 1'b1) : x;
    endfunction

endpackage

// File: rtl/mul_pp4.sv
// rtl/mul_pp4.sv - four-bit partial product sum of a 32-bit magnitude
module mul_pp4
    import mul_pkg::*;
(
    input  logic [XLEN-1:0] mag_a_i,
    input  logic [3:0]      nib_i,
    output logic [XLEN+3:0] pp_o
);

    always_comb begin
        pp_o = '0;
        for (int k = 0; k < 4; k++) begin
            if (nib_i[k]) begin
                pp_o = pp_o + ({4'b0000, mag_a_i} << k);
            end
        end
    end

endmodule

// File: rtl/mul_seq_unit.sv
// rtl/mul_seq_unit.sv - iterative 32x32 multiplier, four multiplier bits per cycle
module mul_seq_unit
    import mul_pkg::*;
(
    input  logic            clk_i,
    input  logic            rst_n_i,
    input  logic            start_i,
    input  logic [1:0]      op_i,
    input  logic [XLEN-1:0] rs1_i,
    input  logic [XLEN-1:0] rs2_i,
    output logic            busy_o,
    output logic            done_o,
    output logic [XLEN-1:0] rd_o
);

    mul_state_e        state_q, state_d;
    mul_op_e           op_q, op_d;
    logic [XLEN-1:0]   mag_a_q, mag_a_d;
    logic [XLEN-1:0]   mag_b_q, mag_b_d;
    logic              neg_q, neg_d;
    logic [2:0]        cnt_q, cnt_d;
    logic [2*XLEN-1:0] acc_q, acc_d;
    logic [XLEN-1:0]   rd_q, rd_d;
    logic              done_q, done_d;

    logic [3:0]        nib;
    logic [XLEN+3:0]   pp;
    logic [2*XLEN-1:0] prod;
    logic              s1, s2;

    assign nib = mag_b_q[{cnt_q, 2'b00} +: 4];

    mul_pp4 u_pp4 (
        .mag_a_i (mag_a_q),
        .nib_i   (nib),
        .pp_o    (pp)
    );

    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        mag_a_d = mag_a_q;
        mag_b_d = mag_b_q;
        neg_d   = neg_q;
        cnt_d   = cnt_q;
        acc_d   = acc_q;
        rd_d    = rd_q;
        done_d  = 1'b0;
        prod    = '0;
        s1      = (op_i != MUL_OP_MULHU);
        s2      = (op_i == MUL_OP_MUL) || (op_i == MUL_OP_MULH);
        unique case (state_q)
            ST_IDLE: begin
                if (start_i) begin
                    state_d = ST_CALC;
                    op_d    = mul_op_e'(op_i);
                    mag_a_d = mag_of(rs1_i, s1);
                    mag_b_d = mag_of(rs2_i, s2);
                    neg_d   = (s1 & rs1_i[XLEN-1]) ^ (s2 & rs2_i[XLEN-1]);
                    cnt_d   = '0;
                    acc_d   = '0;
                end
            end
            ST_CALC: begin
                acc_d = acc_q + ({28'd0, pp} << {cnt_q, 2'b00});
                cnt_d = cnt_q + 3'd1;
                if (cnt_q == 3'(ITER_CNT - 1)) begin
                    state_d = ST_FIX;
                end
            end
            ST_FIX: begin
                prod    = neg_q ? (~acc_q + 64'd1) : acc_q;
                rd_d    = (op_q == MUL_OP_MUL) ? prod[XLEN-1:0] : prod[2*XLEN-1:XLEN];
                done_d  = 1'b1;
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q <= ST_IDLE;
            op_q    <= MUL_OP_MUL;
            mag_a_q <= '0;
            mag_b_q <= '0;
            neg_q   <= 1'b0;
            cnt_q   <= '0;
            acc_q   <= '0;
            rd_q    <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            mag_a_q <= mag_a_d;
            mag_b_q <= mag_b_d;
            neg_q   <= neg_d;
            cnt_q   <= cnt_d;
            acc_q   <= acc_d;
            rd_q    <= rd_d;
            done_q  <= done_d;
        end
    end

    assign busy_o = (state_q != ST_IDLE);
    assign done_o = done_q;
    assign rd_o   = rd_q;

endmodule
